// File: rtl/vga_mem_pkg.sv
// vga_mem_pkg: arbiter state encoding and default burst geometry shared by the VGA memory arbiter.
package vga_mem_pkg;
   typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_CMD} arb_state_t;
   localparam int DEF_BURST = 16;
   localparam int BURST_W   = $clog2(DEF_BURST) + 1;
   localparam int BEAT_W    = $clog2(DEF_BURST);
endpackage

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one Avalon-MM master between scanout burst reads and draw-engine single writes.
module vga_mem_arbiter
   import vga_mem_pkg::*;
#(
   parameter int ADDR_W     = 27,
   parameter int DATA_W     = 128,
   parameter int BURST      = DEF_BURST,
   parameter int STARVE_MAX = 4
) (
   input  logic                    clk_clk,
   input  logic                    reset_reset_n,
   input  logic                    sc_req,
   input  logic [ADDR_W-1:0]       sc_addr,
   output logic                    sc_ack,
   output logic [DATA_W-1:0]       sc_rdata,
   output logic                    sc_rvalid,
   input  logic                    dr_req,
   input  logic [ADDR_W-1:0]       dr_addr,
   input  logic [DATA_W-1:0]       dr_wdata,
   input  logic [DATA_W/8-1:0]     dr_be,
   output logic                    dr_ack,
   output logic [ADDR_W-1:0]       avm_address,
   output logic                    avm_read,
   output logic                    avm_write,
   output logic [DATA_W-1:0]       avm_writedata,
   output logic [DATA_W/8-1:0]     avm_byteenable,
   output logic [$clog2(BURST):0]  avm_burstcount,
   input  logic                    avm_waitrequest,
   input  logic [DATA_W-1:0]       avm_readdata,
   input  logic                    avm_readdatavalid
);
   localparam int BT_W = $clog2(BURST);
   localparam int BC_W = BT_W + 1;
   localparam int SV_W = $clog2(STARVE_MAX + 1);
   localparam int AL_W = $clog2(BURST * DATA_W / 8);
   // Scanout bursts are aligned to the full burst footprint in bytes.
   localparam logic [ADDR_W-1:0] AL_MASK    = ~ADDR_W'((64'd1 << AL_W) - 64'd1);
   localparam logic [BT_W-1:0]   LAST_BEAT  = BT_W'(BURST - 1);
   localparam logic [SV_W-1:0]   STARVE_TOP = SV_W'(STARVE_MAX);

   arb_state_t        state_q, state_d;
   logic [BT_W-1:0]   beat_cnt;
   logic [SV_W-1:0]   starve_cnt;
   logic              rd_grant, wr_grant, beat_in;

   always_comb begin
      wr_grant = (state_q == IDLE) && dr_req && (starve_cnt == STARVE_TOP || !sc_req);
      rd_grant = (state_q == IDLE) && sc_req && !wr_grant;
      beat_in  = (state_q == RD_DATA) && avm_readdatavalid;
      sc_ack   = (state_q == RD_CMD) && !avm_waitrequest;
      dr_ack   = (state_q == WR_CMD) && !avm_waitrequest;
      state_d  = state_q;
      case (state_q)
         IDLE:    state_d = wr_grant ? WR_CMD : rd_grant ? RD_CMD : IDLE;
         RD_CMD:  state_d = sc_ack ? RD_DATA : RD_CMD;
         RD_DATA: state_d = (beat_in && beat_cnt == LAST_BEAT) ? IDLE : RD_DATA;
         WR_CMD:  state_d = dr_ack ? IDLE : WR_CMD;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) state_q <= IDLE;
      else state_q <= state_d;

   // Command outputs come straight from the next state so they launch the cycle after the grant.
   always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) begin
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         avm_address    <= '0;
         avm_writedata  <= '0;
         avm_byteenable <= '0;
         avm_burstcount <= '0;
         sc_rdata       <= '0;
         sc_rvalid      <= 1'b0;
         beat_cnt       <= '0;
         starve_cnt     <= '0;
      end else begin
         avm_read  <= (state_d == RD_CMD);
         avm_write <= (state_d == WR_CMD);
         sc_rvalid <= beat_in;
         if (beat_in) begin
            sc_rdata <= avm_readdata;
            beat_cnt <= beat_cnt + 1'b1;
         end
         if (sc_ack) beat_cnt <= '0;
         if (rd_grant) begin
            avm_address    <= sc_addr & AL_MASK;
            avm_burstcount <= BC_W'(BURST);
            avm_byteenable <= '1;
            if (dr_req && starve_cnt != STARVE_TOP) starve_cnt <= starve_cnt + 1'b1;
         end
         if (wr_grant) begin
            avm_address    <= dr_addr;
            avm_writedata  <= dr_wdata;
            avm_byteenable <= dr_be;
            avm_burstcount <= BC_W'(1);
            starve_cnt     <= '0;
         end
      end
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: scoreboard bench with a behavioural Avalon memory for vga_mem_arbiter.
module tb_vga_mem_arbiter;
   import vga_mem_pkg::*;
   localparam int AW = 27, DW = 128, BL = 16, BEW = DW / 8;

   logic clk_clk = 1'b0, reset_reset_n = 1'b0;
   logic sc_req = 1'b0, dr_req = 1'b0;
   logic [AW-1:0] sc_addr = '0, dr_addr = '0;
   logic [DW-1:0] dr_wdata = '0;
   logic [BEW-1:0] dr_be = '0;
   logic sc_ack, sc_rvalid, dr_ack, avm_read, avm_write;
   logic [DW-1:0] sc_rdata, avm_writedata;
   logic [AW-1:0] avm_address;
   logic [BEW-1:0] avm_byteenable;
   logic [4:0] avm_burstcount;
   logic avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
   logic [DW-1:0] avm_readdata = '0;
   logic [308:0] all_out;

   int n_cmp = 0, n_bad = 0;
   logic [DW-1:0] exp_q[$];
   int wr_wait = 0, lat = 5, cyc = 0, beat_i = 0, start = 0, wait_left = 0;
   bit active = 0, spur = 0, prev_rdv = 0;
   logic [AW-1:0] b_addr = '0;

   vga_mem_arbiter dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .sc_req(sc_req), .sc_addr(sc_addr), .sc_ack(sc_ack), .sc_rdata(sc_rdata), .sc_rvalid(sc_rvalid),
      .dr_req(dr_req), .dr_addr(dr_addr), .dr_wdata(dr_wdata), .dr_be(dr_be), .dr_ack(dr_ack),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
   );

   assign all_out = {avm_read, avm_write, avm_address, avm_writedata, avm_byteenable, avm_burstcount,
                     sc_rdata, sc_rvalid, sc_ack, dr_ack};

   always #5 clk_clk = ~clk_clk;

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input int i);
      return {32'hC0DE_0000 | 32'(i), 5'd0, a, 32'(i) * 32'h0101_0101, 32'hFACE_0000 ^ 32'(a)};
   endfunction

   // Memory model: waitrequest for wr_wait cycles per command, one burst returned lat cycles after accept.
   always @(posedge clk_clk) begin
      #1;
      cyc++;
      prev_rdv = avm_readdatavalid;
      if (!reset_reset_n) begin
         active = 0;
         avm_readdatavalid = 1'b0;
         avm_waitrequest = 1'b0;
         wait_left = wr_wait;
      end else begin
         if (avm_read || avm_write) begin
            avm_waitrequest = (wait_left > 0);
            if (wait_left > 0) wait_left--;
            else if (avm_read && !active) begin
               active = 1; b_addr = avm_address; beat_i = 0; start = cyc + lat;
            end
         end else begin
            avm_waitrequest = 1'b0;
            wait_left = wr_wait;
         end
         if (active && cyc >= start) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = pat(b_addr, beat_i);
            beat_i++;
            active = (beat_i < BL);
         end else begin
            avm_readdatavalid = spur;
            avm_readdata = {4{$urandom}};
         end
      end
   end

   task automatic test_reset;
      @(negedge clk_clk);
      n_cmp++;
      if (all_out !== '0) begin n_bad++; $display("FAIL reset_outputs: got %0h, expected 0", all_out); end
      n_cmp++;
      if (dut.state_q !== IDLE || dut.beat_cnt !== '0 || dut.starve_cnt !== '0) begin
         n_bad++; $display("FAIL reset_state: state %0d beat %0d starve %0d, expected 0/0/0", dut.state_q, dut.beat_cnt, dut.starve_cnt);
      end
   endtask

   task automatic test_read_burst(input logic [AW-1:0] a, input logic [AW-1:0] exp_a);
      int rc, acks, beats;
      for (int i = 0; i < BL; i++) exp_q.push_back(pat(exp_a, i));
      sc_addr = a; sc_req = 1'b1; rc = 0; acks = 0; beats = 0;
      for (int c = 0; c < 200 && beats < BL; c++) begin
         @(negedge clk_clk);
         if (avm_read) begin
            rc++; n_cmp++;
            if ({avm_address, avm_burstcount} !== {exp_a, 5'd16}) begin
               n_bad++; $display("FAIL rd_cmd: addr %0h burst %0d, expected %0h 16", avm_address, avm_burstcount, exp_a);
            end
         end
         if (sc_ack) begin acks++; sc_req = 1'b0; end
         n_cmp++;
         if (sc_rvalid !== prev_rdv) begin n_bad++; $display("FAIL rvalid_latency: got %0b, expected %0b", sc_rvalid, prev_rdv); end
         if (sc_rvalid) begin
            beats++; n_cmp++;
            if (exp_q.size() == 0) begin n_bad++; $display("FAIL rd_beat: unexpected beat %0h, expected none", sc_rdata); end
            else begin
               logic [DW-1:0] e;
               e = exp_q.pop_front();
               if (sc_rdata !== e) begin n_bad++; $display("FAIL rd_beat: got %0h, expected %0h", sc_rdata, e); end
            end
         end
      end
      n_cmp++;
      if (rc != 1 || acks != 1 || beats != BL) begin
         n_bad++; $display("FAIL rd_counts: read cycles %0d acks %0d beats %0d, expected 1 1 16", rc, acks, beats);
      end
      n_cmp++;
      if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL rd_idle: state %0d, expected IDLE", dut.state_q); end
   endtask

   task automatic test_write(input int ws);
      int wcyc, acks, ack_at, first_c;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic [BEW-1:0] eb;
      ea = AW'($urandom); ed = {4{$urandom}}; eb = BEW'($urandom);
      wr_wait = ws;
      @(negedge clk_clk);
      dr_addr = ea; dr_wdata = ed; dr_be = eb; dr_req = 1'b1;
      wcyc = 0; acks = 0; ack_at = 0; first_c = -1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk_clk);
         if (avm_write) begin
            if (first_c < 0) first_c = c;
            wcyc++; n_cmp++;
            if ({avm_address, avm_writedata, avm_byteenable, avm_burstcount} !== {ea, ed, eb, 5'd1}) begin
               n_bad++; $display("FAIL wr_cmd: addr %0h be %0h burst %0d, expected %0h %0h 1", avm_address, avm_byteenable, avm_burstcount, ea, eb);
            end
         end
         if (dr_ack) begin acks++; ack_at = wcyc; dr_req = 1'b0; end
         if (acks > 0 && !avm_write) break;
      end
      n_cmp++;
      if (first_c != 0 || wcyc != ws + 1 || acks != 1 || ack_at != ws + 1) begin
         n_bad++; $display("FAIL wr_timing: first %0d len %0d acks %0d ack_at %0d, expected 0 %0d 1 %0d", first_c, wcyc, acks, ack_at, ws + 1, ws + 1);
      end
   endtask

   task automatic test_arbitration;
      int order[$];
      int exp_o[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      int exp_st;
      exp_st = 0; wr_wait = 0;
      @(negedge clk_clk);
      sc_addr = 27'h400; dr_addr = 27'h50; dr_wdata = {4{32'h1234_5678}}; dr_be = '1;
      sc_req = 1'b1; dr_req = 1'b1;
      for (int c = 0; c < 2000 && order.size() < 10; c++) begin
         @(negedge clk_clk);
         if (sc_ack) begin order.push_back(0); exp_st = (exp_st == 4) ? 4 : exp_st + 1; end
         if (dr_ack) begin order.push_back(1); exp_st = 0; end
         if (sc_ack || dr_ack) begin
            n_cmp++;
            if (dut.starve_cnt !== 3'(exp_st)) begin n_bad++; $display("FAIL starve_cnt: got %0d, expected %0d", dut.starve_cnt, exp_st); end
         end
         if (order.size() == 10) begin sc_req = 1'b0; dr_req = 1'b0; end
      end
      n_cmp++;
      if (order.size() != 10) begin n_bad++; $display("FAIL arb_timeout: grants %0d, expected 10", order.size()); end
      for (int i = 0; i < order.size(); i++) begin
         n_cmp++;
         if (order[i] != exp_o[i]) begin n_bad++; $display("FAIL arb_order[%0d]: got %0d, expected %0d (0=R 1=W)", i, order[i], exp_o[i]); end
      end
      repeat (2) @(negedge clk_clk);
   endtask

   task automatic test_spurious;
      spur = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_clk);
         n_cmp++;
         if (sc_rvalid !== 1'b0) begin n_bad++; $display("FAIL spurious_rvalid: got %0b, expected 0", sc_rvalid); end
      end
      spur = 0;
      @(negedge clk_clk);
   endtask

   task automatic test_reset_midburst;
      int beats;
      bit got;
      for (int i = 0; i < BL; i++) exp_q.push_back(pat(27'h200, i));
      sc_addr = 27'h200; dr_addr = 27'h3AB0; dr_wdata = {4{32'hBEEF_0001}}; dr_be = 16'h00FF;
      sc_req = 1'b1; dr_req = 1'b1; beats = 0;
      for (int c = 0; c < 200 && beats < 8; c++) begin
         @(negedge clk_clk);
         if (sc_ack) sc_req = 1'b0;
         if (sc_rvalid) begin
            logic [DW-1:0] e;
            beats++; n_cmp++;
            e = exp_q.pop_front();
            if (sc_rdata !== e) begin n_bad++; $display("FAIL mid_beat: got %0h, expected %0h", sc_rdata, e); end
         end
      end
      reset_reset_n = 1'b0;
      #1;
      n_cmp++;
      if (all_out !== '0) begin n_bad++; $display("FAIL mid_reset_outputs: got %0h, expected 0", all_out); end
      n_cmp++;
      if (dut.state_q !== IDLE || dut.starve_cnt !== '0 || dut.beat_cnt !== '0) begin
         n_bad++; $display("FAIL mid_reset_state: state %0d starve %0d beat %0d, expected 0/0/0", dut.state_q, dut.starve_cnt, dut.beat_cnt);
      end
      exp_q.delete();
      repeat (2) @(negedge clk_clk);
      reset_reset_n = 1'b1;
      got = 0;
      for (int c = 0; c < 30 && !got; c++) begin
         @(negedge clk_clk);
         n_cmp++;
         if (sc_rvalid !== 1'b0) begin n_bad++; $display("FAIL mid_dropped_beat: rvalid %0b, expected 0", sc_rvalid); end
         if (avm_write) begin
            n_cmp++;
            if ({avm_address, avm_byteenable} !== {27'h3AB0, 16'h00FF}) begin
               n_bad++; $display("FAIL mid_write: addr %0h be %0h, expected 3ab0 ff", avm_address, avm_byteenable);
            end
         end
         if (dr_ack) begin got = 1; dr_req = 1'b0; end
      end
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL mid_dr_ack: no ack, expected ack within 30 cycles"); end
   endtask

   initial begin
      repeat (2) @(negedge clk_clk);
      test_reset;
      reset_reset_n = 1'b1;
      @(negedge clk_clk);
      test_read_burst(27'h100, 27'h100);
      test_read_burst(27'h123, 27'h100);
      test_write(3);
      test_write(0);
      test_arbitration;
      test_spurious;
      test_reset_midburst;
      repeat (3) @(negedge clk_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
